neopix_frame_sched: RTL

NEOPIX_FRAME_SCHED -- requirements
Module: neopix_frame_sched

---
 rtl/neopix_pkg.sv | 14 +
 rtl/neopix_refresh_tmr.sv | 31 +++
 rtl/neopix_frame_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/neopix_pkg.sv
// Shared widths and FSM encoding for the NeoPixel frame scheduler.
package neopix_pkg;

    localparam int PIX_W       = 24;
    localparam int NUM_PIX_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/neopix_refresh_tmr.sv
// Free-running frame-slot counter 0..REFRESH_CYCLES-1; tc_o is high for the single terminal-count cycle.
// No backpressure: counts every cycle regardless of downstream state.
module neopix_refresh_tmr #(
    parameter int unsigned REFRESH_CYCLES = 16_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tc_o
);

    localparam int unsigned   CW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neopix_frame_sched.sv
// Double-buffered pixel frame scheduler: copies back->front on commit at each frame slot and kicks the serializer.
// Latency: terminal count -> tx_start two cycles later; a busy serializer stretches the frame and flags overrun.
module neopix_frame_sched
    import neopix_pkg::*;
#(
    parameter int NUM_PIX        = NUM_PIX_DEF,
    parameter int REFRESH_CYCLES = 16_000_000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [1:0]               wr_addr,
    input  logic [PIX_W-1:0]         wr_grb,
    input  logic                     commit,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [PIX_W*NUM_PIX-1:0] tx_data,
    output logic                     frame_tick,
    output logic                     pending,
    output logic                     overrun
);

    state_t                     state_q, state_d;
    logic                       frame_due_q, frame_due_d;
    logic                       pending_q, pending_d;
    logic                       overrun_q, overrun_d;
    logic                       frame_tick_q;
    logic [PIX_W-1:0]           back_q [NUM_PIX];
    logic [PIX_W*NUM_PIX-1:0]   front_q;
    logic [PIX_W*NUM_PIX-1:0]   back_flat;
    logic                       tc;
    logic                       slot_go;
    logic                       swap;

    neopix_refresh_tmr #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_tmr (
        .clk_i (CLK),
        .rst_i (RST),
        .tc_o  (tc)
    );

    assign slot_go = (state_q == ST_IDLE) && frame_due_q;
    assign swap    = slot_go && pending_q;

    // Pixel 0 occupies the most significant bits of the flattened frame.
    always_comb begin
        back_flat = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            back_flat[(NUM_PIX-1-i)*PIX_W +: PIX_W] = back_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_due_q) state_d = ST_START;
            ST_START: state_d = ST_ACK;
            ST_ACK:   if (tx_busy)     state_d = ST_DRAIN;
            ST_DRAIN: if (!tx_busy)    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A terminal count always wins over consumption, so missed slots collapse into one pending send.
    always_comb begin
        frame_due_d = tc ? 1'b1 : (slot_go ? 1'b0 : frame_due_q);
        overrun_d   = overrun_q | (tc && (state_q != ST_IDLE));
        pending_d   = commit | (pending_q & ~swap);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            frame_due_q  <= 1'b0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            front_q      <= '0;
            for (int i = 0; i < NUM_PIX; i++) begin
                back_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            frame_due_q  <= frame_due_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            frame_tick_q <= swap;
            if (swap) begin
                front_q <= back_flat;
            end
            for (int i = 0; i < NUM_PIX; i++) begin
                if (wr_en && (int'(wr_addr) == i)) begin
                    back_q[i] <= wr_grb;
                end
            end
        end
    end

    assign tx_start   = (state_q == ST_START);
    assign tx_data    = front_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule
